// File: rtl/multi_atomic_counters.sv
// rtl/multi_atomic_counters.sv - bank of wide event counters with an atomic-snapshot narrow read port
module multi_atomic_counters #(
  parameter int NUM_CNT  = 4,
  parameter int CNT_W    = 64,
  parameter int BUS_W    = 32,
  parameter int INC_W    = 4,
  parameter int SATURATE = 0,
  localparam int WORDS   = CNT_W / BUS_W,
  localparam int SEL_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1,
  localparam int WIDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CNT*INC_W-1:0] inc_i,
  input  logic                     req_i,
  input  logic                     atomic_i,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [WIDX_W-1:0]        word_i,
  input  logic                     clr_i,
  output logic                     ack_o,
  output logic [BUS_W-1:0]         count_o,
  output logic [NUM_CNT-1:0]       ovf_o
);

  logic [CNT_W-1:0]   cnt     [NUM_CNT];
  logic [CNT_W:0]     sum     [NUM_CNT];
  logic [CNT_W-1:0]   cnt_nxt [NUM_CNT];
  logic [NUM_CNT-1:0] ovf_hit;
  logic [CNT_W-1:0]   shadow;
  logic [CNT_W-1:0]   rd_val;
  logic [BUS_W-1:0]   sh_word;
  logic               do_atomic;
  logic               do_clr;

  assign do_atomic = req_i & atomic_i;
  assign do_clr    = do_atomic & clr_i;

  // Carry out of the extended sum is the overflow event in both modes.
  always_comb begin
    for (int k = 0; k < NUM_CNT; k++) begin
      sum[k]     = {1'b0, cnt[k]} + (CNT_W+1)'(inc_i[k*INC_W +: INC_W]);
      ovf_hit[k] = sum[k][CNT_W];
      if (SATURATE != 0 && sum[k][CNT_W])
        cnt_nxt[k] = '1;
      else
        cnt_nxt[k] = sum[k][CNT_W-1:0];
    end
  end

  // Read value includes this cycle's increment; unmatched selects read 0.
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_CNT; k++)
      if (sel_i == SEL_W'(k))
        rd_val = cnt_nxt[k];
  end

  always_comb begin
    sh_word = '0;
    for (int w = 0; w < WORDS; w++)
      if (word_i == WIDX_W'(w))
        sh_word = shadow[w*BUS_W +: BUS_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CNT; k++)
        cnt[k] <= '0;
      ovf_o   <= '0;
      shadow  <= '0;
      ack_o   <= 1'b0;
      count_o <= '0;
    end else begin
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt[k] <= cnt_nxt[k];
        if (ovf_hit[k])
          ovf_o[k] <= 1'b1;
        // Clear wins over a same-cycle overflow; the increment is already in rd_val.
        if (do_clr && sel_i == SEL_W'(k)) begin
          cnt[k]   <= '0;
          ovf_o[k] <= 1'b0;
        end
      end
      ack_o <= req_i;
      if (!req_i)
        count_o <= '0;
      else if (atomic_i)
        count_o <= rd_val[BUS_W-1:0];
      else
        count_o <= sh_word;
      if (do_atomic)
        shadow <= rd_val;
    end
  end

endmodule

// File: tb/tb_multi_atomic_counters.sv
// tb/tb_multi_atomic_counters.sv - scoreboard bench for multi_atomic_counters
module tb_multi_atomic_counters;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Full-size instance (64-bit counters, 32-bit bus)
  logic [15:0] inc_m;
  logic        req_m, atomic_m, clr_m;
  logic [1:0]  sel_m;
  logic [0:0]  word_m;
  logic        ack_m;
  logic [31:0] count_m;
  logic [3:0]  ovf_m;

  // Narrow instances (8-bit counters, 4-bit bus) so wrap/saturate/word carry are reachable
  logic [15:0] inc_s;
  logic        req_s, atomic_s, clr_s;
  logic [1:0]  sel_s;
  logic [0:0]  word_s;
  logic        ack_w, ack_s;
  logic [3:0]  count_w, count_s;
  logic [3:0]  ovf_w, ovf_s;

  multi_atomic_counters #(.NUM_CNT(4), .CNT_W(64), .BUS_W(32), .INC_W(4), .SATURATE(0)) dut_m (
    .clk(clk), .reset(reset), .inc_i(inc_m), .req_i(req_m), .atomic_i(atomic_m),
    .sel_i(sel_m), .word_i(word_m), .clr_i(clr_m), .ack_o(ack_m), .count_o(count_m), .ovf_o(ovf_m));

  multi_atomic_counters #(.NUM_CNT(4), .CNT_W(8), .BUS_W(4), .INC_W(4), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .inc_i(inc_s), .req_i(req_s), .atomic_i(atomic_s),
    .sel_i(sel_s), .word_i(word_s), .clr_i(clr_s), .ack_o(ack_w), .count_o(count_w), .ovf_o(ovf_w));

  multi_atomic_counters #(.NUM_CNT(4), .CNT_W(8), .BUS_W(4), .INC_W(4), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .inc_i(inc_s), .req_i(req_s), .atomic_i(atomic_s),
    .sel_i(sel_s), .word_i(word_s), .clr_i(clr_s), .ack_o(ack_s), .count_o(count_s), .ovf_o(ovf_s));

  int checks = 0;
  int errors = 0;
  logic [31:0] q_m[$];
  logic [3:0]  q_w[$];
  logic [3:0]  q_s[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_m(input logic at, input int sel, input int wd, input logic clr, input logic [31:0] exp);
    req_m = 1'b1; atomic_m = at; sel_m = 2'(sel); word_m = 1'(wd); clr_m = clr;
    q_m.push_back(exp);
    step();
    req_m = 1'b0; atomic_m = 1'b0; clr_m = 1'b0;
  endtask

  task automatic rd_s(input logic at, input int sel, input int wd, input logic clr,
                      input logic [3:0] exp_w, input logic [3:0] exp_s);
    req_s = 1'b1; atomic_s = at; sel_s = 2'(sel); word_s = 1'(wd); clr_s = clr;
    q_w.push_back(exp_w);
    q_s.push_back(exp_s);
    step();
    req_s = 1'b0; atomic_s = 1'b0; clr_s = 1'b0;
  endtask

  // Response monitor: every ack pops one expected value; count_o must be 0 when idle.
  always @(negedge clk) begin
    if (ack_m) begin
      chk("m_ack_expected", 64'(q_m.size() != 0), 64'd1);
      if (q_m.size() != 0) chk("m_count", 64'(count_m), 64'(q_m.pop_front()));
    end else chk("m_idle_count", 64'(count_m), 64'd0);
    if (ack_w) begin
      chk("w_ack_expected", 64'(q_w.size() != 0), 64'd1);
      if (q_w.size() != 0) chk("w_count", 64'(count_w), 64'(q_w.pop_front()));
    end else chk("w_idle_count", 64'(count_w), 64'd0);
    if (ack_s) begin
      chk("s_ack_expected", 64'(q_s.size() != 0), 64'd1);
      if (q_s.size() != 0) chk("s_count", 64'(count_s), 64'(q_s.pop_front()));
    end else chk("s_idle_count", 64'(count_s), 64'd0);
  end

  initial begin
    reset = 1'b1;
    inc_m = '0; req_m = 0; atomic_m = 0; sel_m = '0; word_m = '0; clr_m = 0;
    inc_s = '0; req_s = 0; atomic_s = 0; sel_s = '0; word_s = '0; clr_s = 0;
    step(); step();
    chk("rst_ack_m", 64'(ack_m), 64'd0);
    chk("rst_count_m", 64'(count_m), 64'd0);
    chk("rst_ovf_m", 64'(ovf_m), 64'd0);
    chk("rst_ovf_w", 64'(ovf_w), 64'd0);
    reset = 1'b0;

    // Idle counters read zero
    repeat (5) step();
    rd_m(1, 0, 0, 0, 32'd0);
    rd_m(0, 0, 1, 0, 32'd0);

    // ch1 += 3 for 10 cycles, read in the 10th and 11th
    inc_m = 16'h0030;
    repeat (9) step();
    rd_m(1, 1, 0, 0, 32'd30);
    rd_m(1, 1, 0, 0, 32'd33);
    inc_m = '0;
    rd_m(0, 0, 1, 0, 32'd0);
    rd_m(0, 2, 0, 0, 32'd33);

    // Clear-on-read of ch3 at 100 while += 2 each cycle
    inc_m = 16'h2000;
    repeat (50) step();
    rd_m(1, 3, 0, 1, 32'd102);
    repeat (3) step();
    rd_m(1, 3, 0, 0, 32'd8);
    rd_m(0, 0, 0, 0, 32'd8);
    rd_m(1, 1, 0, 0, 32'd33);
    chk("ovf_m_none", 64'(ovf_m), 64'd0);

    // Reset overrides a pending request and running increments
    req_m = 1'b1; atomic_m = 1'b1; sel_m = 2'd1; reset = 1'b1;
    step();
    req_m = 1'b0; atomic_m = 1'b0; reset = 1'b0; inc_m = '0;
    chk("rst2_ack_m", 64'(ack_m), 64'd0);
    chk("rst2_count_m", 64'(count_m), 64'd0);
    chk("rst2_ovf_m", 64'(ovf_m), 64'd0);
    for (int ch = 0; ch < 4; ch++) rd_m(1, ch, 0, 0, 32'd0);

    // Narrow instances: ch0 to 254, then +5 -> wrap 3 / saturate 255
    inc_s = 16'h000F;
    repeat (16) step();
    inc_s = 16'h000E;
    step();
    chk("pre_ovf_w", 64'(ovf_w), 64'd0);
    chk("pre_ovf_s", 64'(ovf_s), 64'd0);
    inc_s = 16'h0005;
    rd_s(1, 0, 0, 0, 4'h3, 4'hF);
    inc_s = '0;
    rd_s(0, 0, 1, 0, 4'h0, 4'hF);
    chk("wrap_ovf_w", 64'(ovf_w), 64'h1);
    chk("sat_ovf_s", 64'(ovf_s), 64'h1);
    rd_s(1, 0, 0, 1, 4'h3, 4'hF);
    chk("clr_ovf_w", 64'(ovf_w), 64'h0);
    chk("clr_ovf_s", 64'(ovf_s), 64'h0);

    // ch1 exactly at all-ones: no overflow until a nonzero increment
    inc_s = 16'h00F0;
    repeat (17) step();
    inc_s = '0;
    repeat (3) step();
    chk("full_ovf_w", 64'(ovf_w), 64'h0);
    chk("full_ovf_s", 64'(ovf_s), 64'h0);
    inc_s = 16'h0010;
    step();
    inc_s = '0;
    chk("edge_ovf_w", 64'(ovf_w), 64'h2);
    chk("edge_ovf_s", 64'(ovf_s), 64'h2);
    rd_s(1, 1, 0, 0, 4'h0, 4'hF);
    rd_s(0, 0, 1, 0, 4'h0, 4'hF);

    // ch2 crosses a word boundary: 0x0E + 4 = 0x12, words stay consistent while running
    inc_s = 16'h0E00;
    step();
    inc_s = 16'h0400;
    rd_s(1, 2, 0, 0, 4'h2, 4'h2);
    rd_s(0, 3, 1, 0, 4'h1, 4'h1);
    rd_s(0, 0, 0, 0, 4'h2, 4'h2);
    inc_s = '0;

    step(); step();
    chk("m_drain", 64'(q_m.size()), 64'd0);
    chk("w_drain", 64'(q_w.size()), 64'd0);
    chk("s_drain", 64'(q_s.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_atomic_counters.md
# multi_atomic_counters

Parametrised bank of NUM_CNT wide event counters, read over a narrow BUS_W-bit request/ack port with atomic snapshot semantics. It generalises the single 64-bit atomic counter to N channels, multi-bit increments, arbitrary counter/bus width ratios, selectable wrap/saturate mode, sticky overflow flags and clear-on-read. It sits beside the performance-monitor event sources, with the register-read fabric driving req_i.

## Interface
- NUM_CNT, 4, number of independent counters (≥1)
- CNT_W, 64, counter width; must be an integer multiple of BUS_W
- BUS_W, 32, read data width
- INC_W, 4, per-channel increment width
- SATURATE, 0, 0 = counters wrap modulo 2^CNT_W; 1 = counters clamp at all-ones
- Derived: WORDS = CNT_W/BUS_W; SEL_W = max(1,$clog2(NUM_CNT)); WIDX_W = max(1,$clog2(WORDS))

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- inc_i  in  NUM_CNT*INC_W  per-channel increment; channel k = bits [k*INC_W +: INC_W]; 0 = no event
- req_i  in  1  read request, single-cycle; may be asserted every cycle
- atomic_i  in  1  qualifies req_i: 1 = live read of word 0 and snapshot of the whole counter
- sel_i  in  SEL_W  channel select; used only for atomic reads; values ≥ NUM_CNT read as 0 and snapshot 0
- word_i  in  WIDX_W  word index for non-atomic reads; values ≥ WORDS read as 0
- clr_i  in  1  with req_i & atomic_i: clear the selected counter and its overflow flag after the read
- ack_o  out  1  read response valid
- count_o  out  BUS_W  read data; 0 whenever ack_o = 0
- ovf_o  out  NUM_CNT  sticky per-channel overflow flags

## Operation
- Each counter cnt[k] (CNT_W bits) adds inc_i[k] every cycle, zero-extended.
- Wrap mode: cnt <= cnt + inc, modulo 2^CNT_W; ovf[k] sets when the addition carries out.
- Saturate mode: if cnt + inc > 2^CNT_W − 1, cnt <= all-ones and ovf[k] sets; otherwise normal add. A counter at all-ones with inc = 0 does not set ovf.
- ovf[k] is sticky and clears only on reset or a clear-on-read of channel k.
- One shared shadow register, CNT_W bits, initialised to 0.
- Atomic read (req_i & atomic_i in cycle t):
  - The read value V = cnt[sel_i] including inc_i of cycle t.
  - The response returns V[BUS_W−1:0].
  - The shadow loads V.
- Non-atomic read (req_i & !atomic_i in cycle t): returns shadow word word_i, i.e. shadow[word_i*BUS_W +: BUS_W]. sel_i is ignored and the shadow is unchanged.
- Clear-on-read (req_i & atomic_i & clr_i):
  - At the end of cycle t, cnt[sel_i] <= 0 and ovf[sel_i] <= 0. Clear takes priority over a same-cycle overflow.
  - The increment of cycle t is included in V, so no events are lost.
  - clr_i is ignored without req_i & atomic_i.
- Software flow for a consistent wide value: one atomic read (word 0), then non-atomic reads of words 1..WORDS−1.

## Timing
- Reset, synchronous on the clk edge with reset = 1: all counters, ovf_o, shadow, ack_o and count_o go to 0. Reset overrides same-cycle inc_i and req_i. No response is generated for a request in the reset cycle.
- Read latency is 1 cycle. req_i in cycle t gives ack_o = 1 with count_o valid in cycle t+1, both driven from registers. There is no backpressure, so every request is acked.
- Back-to-back requests: a non-atomic read in cycle t+1 sees the shadow loaded by an atomic read in cycle t.
- Counter values and ovf_o update at the edge ending cycle t. ovf_o is visible in cycle t+1.
- WORDS = 1: the shadow still exists, and non-atomic word 0 returns the last atomic value.

## Test plan
- Reset, then inc_i = 0 for 5 cycles, then atomic read of ch0 -> ack_o = 1 next cycle with count_o = 0; ack_o = 0 and count_o = 0 in all other cycles.
- ch1 inc = 3 for 10 cycles with an atomic read of ch1 in the 10th cycle -> count_o = 30. A read one cycle later returns 33 if inc continues.
- Preload ch2 to 0x0000_0000_FFFF_FFFE by running inc; apply inc = 4, then atomic read followed by non-atomic word 1 -> word 0 = 0x0000_0002, word 1 = 0x0000_0001. Words stay consistent while the counter keeps running.
- Wrap mode: ch0 at 2^64 − 2, inc = 5 -> cnt = 3 and ovf_o[0] = 1. With SATURATE = 1, the same stimulus gives cnt = all-ones and ovf_o[0] = 1.
- Atomic read of ch3 with clr_i while inc = 2 every cycle, ch3 = 100 before the read cycle -> returns 102. The next atomic read, 4 cycles later, returns 8. ovf_o[3] is cleared.
- Assert reset while a request is pending and counters are non-zero -> the next cycle shows ack_o = 0, count_o = 0, ovf_o = 0, and all counters read 0.
